// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU results and aligned load returns into one registered
// register-file write per cycle, with a small load queue and pending-destination mask.
module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LQ_DEPTH   = 4
) (
  input  logic                        CLOCK,
  input  logic                        RESET_L,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_WIDTH-1:0]       alu_dest,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_WIDTH-1:0]       ld_dest,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  input  logic [1:0]                  ld_addr_lo,
  input  logic [1:0]                  ld_size,
  input  logic                        ld_signed,
  input  logic                        ld_merge,
  output logic [ADDR_WIDTH-1:0]       dest_addr,
  output logic [DATA_WIDTH-1:0]       write_datas_in,
  output logic                        writeReg_L,
  output logic                        writeHighEx_L,
  output logic                        writeHighAx_L,
  output logic                        writeLowEx_L,
  output logic                        writeLowAx_L,
  output logic [(1<<ADDR_WIDTH)-1:0]  pend_mask,
  output logic                        err_misalign,
  output logic                        err_waw
);

  localparam int IDX_W = $clog2(LQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Handshake: a channel transfers on a cycle where valid and ready are both 1;
  // ready never depends on valid, and a producer holds its payload until accepted.

  logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
  logic [3:0]            q_lane [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0] q_dest [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   q_vld;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  q_full, q_empty;
  logic [3:0]            lane_l;

  assign wr_idx  = wr_ptr[IDX_W-1:0];
  assign rd_idx  = rd_ptr[IDX_W-1:0];
  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);

  assign alu_ready = ~q_full;
  assign ld_ready  = ~q_full;

  // Load alignment and lane selection happen before the queue, so the head is issue-ready.
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_val;
  logic [3:0]            ld_lanes;
  logic                  ld_legal;

  always_comb begin
    ld_byte  = ld_data[8*ld_addr_lo +: 8];
    ld_half  = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    ld_val   = ld_data;
    ld_lanes = 4'b1111;
    ld_legal = 1'b1;
    case (ld_size)
      2'd0: begin
        ld_val = {{(DATA_WIDTH-8){ld_signed & ld_byte[7]}}, ld_byte};
        if (ld_merge) ld_lanes = 4'b0001;
      end
      2'd1: begin
        ld_val   = {{(DATA_WIDTH-16){ld_signed & ld_half[15]}}, ld_half};
        ld_legal = ~ld_addr_lo[0];
        if (ld_merge) ld_lanes = 4'b0011;
      end
      2'd2:    ld_legal = (ld_addr_lo == 2'd0);
      default: ld_legal = 1'b0;
    endcase
  end

  logic ld_acc, alu_acc, push, pop;

  assign ld_acc  = ld_valid & ~q_full;
  assign alu_acc = alu_valid & ~q_full;
  assign push    = ld_acc & ld_legal & (ld_dest != '0);
  assign pop     = q_full | (~alu_valid & ~q_empty);

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (q_vld[i]) pend_mask[q_dest[i]] = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (push) begin
      q_data[wr_idx] <= ld_val;
      q_lane[wr_idx] <= ld_lanes;
      q_dest[wr_idx] <= ld_dest;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_vld          <= '0;
      err_misalign   <= 1'b0;
      err_waw        <= 1'b0;
      writeReg_L     <= 1'b1;
      lane_l         <= 4'b1111;
      dest_addr      <= '0;
      write_datas_in <= '0;
    end else begin
      // Push and pop never hit the same slot: push needs not-full, pop needs not-empty.
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        q_vld[wr_idx] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        q_vld[rd_idx] <= 1'b0;
      end
      if (ld_acc && !ld_legal) err_misalign <= 1'b1;
      if (alu_acc && (alu_dest != '0) && pend_mask[alu_dest]) err_waw <= 1'b1;

      if (pop) begin
        writeReg_L     <= 1'b0;
        lane_l         <= ~q_lane[rd_idx];
        dest_addr      <= q_dest[rd_idx];
        write_datas_in <= q_data[rd_idx];
      end else if (alu_acc && (alu_dest != '0)) begin
        writeReg_L     <= 1'b0;
        lane_l         <= 4'b0000;
        dest_addr      <= alu_dest;
        write_datas_in <= alu_data;
      end else begin
        writeReg_L <= 1'b1;
        lane_l     <= 4'b1111;
      end
    end
  end

  assign writeHighEx_L = lane_l[3];
  assign writeHighAx_L = lane_l[2];
  assign writeLowEx_L  = lane_l[1];
  assign writeLowAx_L  = lane_l[0];

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of the 32x32 register file; owns its single write port.
- Merges an ALU result channel and a load-return channel into one registered write per cycle.
- Aligns byte/halfword loads and sign- or zero-extends them, or merges them into the low bytes via byte-lane enables.
- Buffers loads in a small FIFO and exports a pending-destination mask for issue-side hazard stalls.

Parameters:
- DATA_WIDTH, 32, register/data width; only 32 is supported.
- ADDR_WIDTH, 5, register address width.
- LQ_DEPTH, 4, load-queue entries; must be a power of 2 and at least 2.

Ports:
- CLOCK  in  1  single clock; all state updates on the posedge.
- RESET_L  in  1  asynchronous reset, active low.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_dest  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load return present.
- ld_ready  out  1  load accepted this cycle; equals the load queue not being full.
- ld_dest  in  5  load destination register.
- ld_data  in  32  raw aligned memory word.
- ld_addr_lo  in  2  byte offset of the load.
- ld_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- ld_signed  in  1  sign-extend when 1, zero-extend when 0; ignored for word loads.
- ld_merge  in  1  1 = write only the low lanes and keep the other register bytes.
- dest_addr  out  5  to register file.
- write_datas_in  out  32  to register file.
- writeReg_L  out  1  register write enable, active low.
- writeHighEx_L  out  1  byte-lane enable for bits 31:24, active low.
- writeHighAx_L  out  1  byte-lane enable for bits 23:16, active low.
- writeLowEx_L  out  1  byte-lane enable for bits 15:8, active low.
- writeLowAx_L  out  1  byte-lane enable for bits 7:0, active low.
- pend_mask  out  32  bit r set while any valid queue entry targets r; combinational from queue state.
- err_misalign  out  1  sticky misaligned/illegal-load flag; cleared only by reset.
- err_waw  out  1  sticky flag: ALU accepted while pend_mask[alu_dest] was set.

Behaviour:
- Reset (RESET_L=0, async):
  - Queue empty, pend_mask=0, both error flags 0.
  - writeReg_L and all four lane enables =1.
  - dest_addr=0, write_datas_in=0.
- All write-port outputs are registered. A result accepted in cycle t drives the port during t+1, and the register file commits at the edge ending t+1.
- At most one write is issued per cycle.
- Arbitration each cycle:
  - Queue full: the queue head issues and alu_ready=0; the ALU holds its result.
  - Else if alu_valid: the ALU issues and alu_ready=1.
  - Else if the queue is non-empty: the head issues.
  - Else idle: writeReg_L=1 and all lane enables=1.
- alu_ready is 1 whenever the queue is not full, even with alu_valid=0.
- Queue push when ld_valid & ld_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - ld_ready depends only on the current full status, not on a same-cycle pop.
- Pointer wrap: the read and write pointers are log2(LQ_DEPTH)+1 bits; full/empty are decided by comparing the MSB.
- Load alignment is computed at push; the queue stores the final 32-bit data and 4-bit lane mask.
  - Byte: the value is ld_data byte lane ld_addr_lo.
  - Half: the value is halfword ld_addr_lo[1].
  - Extension per ld_signed.
- Lane rules:
  - Non-merge: all 4 lanes enabled.
  - Merge byte: lane 7:0 only; value in bits 7:0.
  - Merge half: lanes 15:0 only; value in bits 15:0.
  - Word: all lanes; ld_merge is ignored.
- Illegal loads (half with ld_addr_lo[0]=1, word with ld_addr_lo!=0, or ld_size=3):
  - Accepted, not queued; no write; err_misalign set.
- Destination 0:
  - ALU: accepted, no write, no err_waw.
  - Load: accepted, not queued, no pend_mask bit.
- On an issued write: writeReg_L=0 and the lane enables equal the inverted lane mask. dest_addr and write_datas_in take the issued values.
- ALU issue: all lanes enabled.
- pend_mask is the OR over valid entries of one-hot(dest). A bit clears only when the last entry with that dest leaves the queue.
- err_waw sets when the ALU is accepted with alu_dest!=0 and pend_mask[alu_dest]=1. The write still occurs.
- Reset mid-operation: queue contents are discarded, and any write in flight on the port is cancelled immediately (writeReg_L=1 asynchronously).

Test Plan:
- Reset release, alu_valid=1, dest=5, data=0x12345678 → next cycle: writeReg_L=0, dest_addr=5, data=0x12345678, all lane enables 0.
- Load byte, addr_lo=2, signed, ld_data=0x00800000, dest=7, ALU idle → write data=0xFFFFFF80 with all lanes; same load unsigned → 0x00000080.
- Merge half, addr_lo=2, ld_data=0xBEEF0000, dest=9 → data low 16 bits=0xBEEF, writeLowAx_L=writeLowEx_L=0, both High enables=1.
- 4 loads pushed while alu_valid held at 1 → queue full, ld_ready=0 and alu_ready=0. Next cycle the head issues and ld_ready returns to 1.
- Two queued loads to dest 3 → pend_mask[3]=1 until the second one issues. An ALU write to 3 in between sets err_waw=1.
- Half load with addr_lo=1 → no write, no push, err_misalign=1. Asserting RESET_L=0 while the queue holds 2 entries → pend_mask=0 and writeReg_L=1 immediately.
